// File: rtl/settings_pkg.sv
// Shared modulation settings bundle and transition mode codes.
// Consumed by the segment swapper and its trigger helper.
package settings;

  localparam int IDX_W   = 15;
  localparam int REP_W   = 16;
  localparam int VALUE_W = 64;

  localparam logic [7:0] TRANSITION_MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0] TRANSITION_MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0] TRANSITION_MODE_GPIO      = 8'h02;
  localparam logic [7:0] TRANSITION_MODE_EXT       = 8'h10;
  localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

  localparam logic [REP_W-1:0] REP_INFINITE = 16'hFFFF;

  typedef struct packed {
    logic                        UPDATE;
    logic                        REQ_RD_SEGMENT;
    logic [7:0]                  TRANSITION_MODE;
    logic [VALUE_W-1:0]          TRANSITION_VALUE;
    logic [1:0][IDX_W-1:0]       CYCLE;
    logic [1:0][REP_W-1:0]       REP;
  } mod_settings_t;

endpackage

// File: rtl/mod_segment_swapper_trigger.sv
// Trigger strobes for the segment swapper: index wrap, time match, GPIO edge.
// GPIO edge detector exists only with MOD_TRANSITION_GPIO_EN defined.
module transition_trigger
  import settings::*;
#(
  parameter int SYS_TIME_WIDTH = 56
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IDX_W-1:0]          idx,
  input  logic [IDX_W-1:0]          cycle_len,
  input  logic [SYS_TIME_WIDTH-1:0] sys_time,
  input  logic [SYS_TIME_WIDTH-1:0] time_value,
  input  logic [3:0]                gpio_in,
  input  logic [1:0]                gpio_sel,
  output logic                      wrap,
  output logic                      time_hit,
  output logic                      gpio_edge
);

  logic [IDX_W-1:0] prev_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_idx <= '0;
    else     prev_idx <= idx;
  end

  assign wrap     = (prev_idx == cycle_len) && (idx == '0);
  assign time_hit = sys_time >= time_value;

`ifdef MOD_TRANSITION_GPIO_EN
  logic [3:0] gpio_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gpio_q <= '0;
    else     gpio_q <= gpio_in;
  end

  assign gpio_edge = gpio_in[gpio_sel] & ~gpio_q[gpio_sel];
`else
  logic unused_gpio;
  assign unused_gpio = ^{gpio_in, gpio_sel};
  assign gpio_edge   = 1'b0;
`endif

endmodule

// File: rtl/mod_segment_swapper.sv
// Chooses the modulation read segment from controller settings and triggers.
// GPIO transitions are built only with MOD_TRANSITION_GPIO_EN defined.
module mod_segment_swapper
  import settings::*;
#(
  parameter int SYS_TIME_WIDTH = 56
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  mod_settings_t             MOD_SETTINGS,
  input  logic [SYS_TIME_WIDTH-1:0] SYS_TIME,
  input  logic [3:0]                GPIO_IN,
  input  logic [IDX_W-1:0]          IDX,
  output logic                      SEGMENT,
  output logic                      STOP,
  output logic [REP_W-1:0]          LOOP_CNT
);

  typedef enum logic [2:0] {
    RUN, WAIT_IDX, WAIT_TIME, WAIT_GPIO, EXT_RUN
  } state_t;

  state_t state, state_n;

  logic                      req_seg;
  logic [SYS_TIME_WIDTH-1:0] time_val;
  logic [1:0]                gpio_sel;

  logic       accept, swap, swap_seg;
  logic       seg_n, stop_n;
  logic [REP_W-1:0] cnt_n;
  logic       wrap, time_hit, gpio_edge;
  logic [3:0] gpio_pins;

  logic [7:0]       mode;
  logic [REP_W-1:0] rep_cur;

  assign mode    = MOD_SETTINGS.TRANSITION_MODE;
  assign rep_cur = MOD_SETTINGS.REP[SEGMENT];

  logic unused_value;
  assign unused_value = ^MOD_SETTINGS.TRANSITION_VALUE;

`ifdef MOD_TRANSITION_GPIO_EN
  assign gpio_pins = GPIO_IN;
`else
  logic unused_pins;
  assign unused_pins = ^GPIO_IN;
  assign gpio_pins   = '0;
`endif

  transition_trigger #(
    .SYS_TIME_WIDTH(SYS_TIME_WIDTH)
  ) u_trigger (
    .clk       (CLK),
    .rst       (RST),
    .idx       (IDX),
    .cycle_len (MOD_SETTINGS.CYCLE[SEGMENT]),
    .sys_time  (SYS_TIME),
    .time_value(time_val),
    .gpio_in   (gpio_pins),
    .gpio_sel  (gpio_sel),
    .wrap      (wrap),
    .time_hit  (time_hit),
    .gpio_edge (gpio_edge)
  );

  // A fresh UPDATE always beats whatever the old request was waiting on.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    swap     = 1'b0;
    swap_seg = req_seg;
    if (MOD_SETTINGS.UPDATE) begin
      unique case (1'b1)
        mode == TRANSITION_MODE_IMMEDIATE: begin
          accept   = 1'b1;
          swap     = 1'b1;
          swap_seg = MOD_SETTINGS.REQ_RD_SEGMENT;
          state_n  = RUN;
        end
        mode == TRANSITION_MODE_EXT: begin
          accept   = 1'b1;
          swap     = 1'b1;
          swap_seg = MOD_SETTINGS.REQ_RD_SEGMENT;
          state_n  = EXT_RUN;
        end
        mode == TRANSITION_MODE_SYNC_IDX: begin
          accept  = 1'b1;
          state_n = WAIT_IDX;
        end
        mode == TRANSITION_MODE_SYS_TIME: begin
          accept  = 1'b1;
          state_n = WAIT_TIME;
        end
`ifdef MOD_TRANSITION_GPIO_EN
        mode == TRANSITION_MODE_GPIO: begin
          accept  = 1'b1;
          state_n = WAIT_GPIO;
        end
`endif
        default: ;
      endcase
    end else begin
      unique case (state)
        WAIT_IDX: if (wrap) begin
          swap    = 1'b1;
          state_n = RUN;
        end
        WAIT_TIME: if (time_hit) begin
          swap    = 1'b1;
          state_n = RUN;
        end
        WAIT_GPIO: if (gpio_edge) begin
          swap    = 1'b1;
          state_n = RUN;
        end
        EXT_RUN: if (wrap && rep_cur == REP_INFINITE) begin
          swap     = 1'b1;
          swap_seg = ~SEGMENT;
        end
        default: ;
      endcase
    end
  end

  // A swap outranks loop counting, so a coincident wrap never leaves LOOP_CNT at 1.
  always_comb begin
    seg_n  = SEGMENT;
    cnt_n  = LOOP_CNT;
    stop_n = STOP;
    if (swap) begin
      seg_n  = swap_seg;
      cnt_n  = '0;
      stop_n = 1'b0;
    end else if (wrap && state != EXT_RUN) begin
      if (rep_cur != REP_INFINITE && LOOP_CNT == rep_cur)
        stop_n = 1'b1;
      else if (LOOP_CNT != REP_INFINITE)
        cnt_n = LOOP_CNT + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= RUN;
      SEGMENT  <= 1'b0;
      STOP     <= 1'b0;
      LOOP_CNT <= '0;
      req_seg  <= 1'b0;
      time_val <= '0;
      gpio_sel <= '0;
    end else begin
      state    <= state_n;
      SEGMENT  <= seg_n;
      STOP     <= stop_n;
      LOOP_CNT <= cnt_n;
      if (accept) begin
        req_seg  <= MOD_SETTINGS.REQ_RD_SEGMENT;
        time_val <= MOD_SETTINGS.TRANSITION_VALUE[SYS_TIME_WIDTH-1:0];
        gpio_sel <= MOD_SETTINGS.TRANSITION_VALUE[1:0];
      end
    end
  end

endmodule

// File: tb/tb_mod_segment_swapper.sv
// Directed bench for mod_segment_swapper; GPIO checks follow MOD_TRANSITION_GPIO_EN.
module tb_mod_segment_swapper;
  import settings::*;

  localparam int SW = 56;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  mod_settings_t    ms;
  logic [SW-1:0]    SYS_TIME;
  logic [3:0]       GPIO_IN;
  logic [IDX_W-1:0] IDX;
  logic             SEGMENT;
  logic             STOP;
  logic [REP_W-1:0] LOOP_CNT;

  int total = 0;
  int bad   = 0;

  mod_segment_swapper #(.SYS_TIME_WIDTH(SW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .MOD_SETTINGS(ms),
    .SYS_TIME    (SYS_TIME),
    .GPIO_IN     (GPIO_IN),
    .IDX         (IDX),
    .SEGMENT     (SEGMENT),
    .STOP        (STOP),
    .LOOP_CNT    (LOOP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic [7:0] mode, input logic req,
                     input logic [63:0] val);
    ms.TRANSITION_MODE  = mode;
    ms.REQ_RD_SEGMENT   = req;
    ms.TRANSITION_VALUE = val;
    ms.UPDATE           = 1'b1;
    tick();
    ms.UPDATE           = 1'b0;
  endtask

  task automatic step(input int v);
    IDX = v[IDX_W-1:0];
    tick();
  endtask

  // One full pass 1,2,3,0 with CYCLE=3: wrap lands on the edge of step(0).
  task automatic loop_once();
    step(1);
    step(2);
    step(3);
    step(0);
  endtask

  initial begin
    ms                  = '0;
    ms.CYCLE[0]         = 15'd3;
    ms.CYCLE[1]         = 15'd3;
    ms.REP[0]           = 16'hFFFF;
    ms.REP[1]           = 16'hFFFF;
    SYS_TIME            = '0;
    GPIO_IN             = '0;
    IDX                 = '0;
    tick();
    tick();
    check("rst_seg", SEGMENT, 0);
    check("rst_stop", STOP, 0);
    check("rst_cnt", LOOP_CNT, 0);
    RST = 1'b0;
    tick();

    upd(TRANSITION_MODE_IMMEDIATE, 1'b1, 0);
    check("imm_seg", SEGMENT, 1);
    check("imm_cnt", LOOP_CNT, 0);
    upd(TRANSITION_MODE_IMMEDIATE, 1'b0, 0);
    check("imm_back", SEGMENT, 0);

    upd(TRANSITION_MODE_SYNC_IDX, 1'b1, 0);
    step(1);
    check("sync_i1", SEGMENT, 0);
    step(2);
    step(3);
    check("sync_i3", SEGMENT, 0);
    step(0);
    check("sync_wrap", SEGMENT, 1);
    check("sync_cnt", LOOP_CNT, 0);

    upd(TRANSITION_MODE_IMMEDIATE, 1'b0, 0);
    SYS_TIME = 56'd999;
    upd(TRANSITION_MODE_SYS_TIME, 1'b1, 64'd1000);
    tick();
    check("time_999", SEGMENT, 0);
    SYS_TIME = 56'd1000;
    tick();
    check("time_1000", SEGMENT, 1);
    upd(TRANSITION_MODE_SYS_TIME, 1'b0, 64'd5);
    check("past_hold", SEGMENT, 1);
    tick();
    check("past_swap", SEGMENT, 0);

    ms.REP[1] = 16'd2;
    upd(TRANSITION_MODE_IMMEDIATE, 1'b1, 0);
    loop_once();
    check("rep_w1_cnt", LOOP_CNT, 1);
    check("rep_w1_stop", STOP, 0);
    loop_once();
    check("rep_w2_cnt", LOOP_CNT, 2);
    check("rep_w2_stop", STOP, 0);
    loop_once();
    check("rep_w3_stop", STOP, 1);
    check("rep_w3_cnt", LOOP_CNT, 2);
    upd(TRANSITION_MODE_IMMEDIATE, 1'b0, 0);
    check("rep_clr_stop", STOP, 0);
    check("rep_clr_seg", SEGMENT, 0);
    check("rep_clr_cnt", LOOP_CNT, 0);
    ms.REP[1] = 16'hFFFF;

    upd(TRANSITION_MODE_EXT, 1'b0, 0);
    check("ext_start", SEGMENT, 0);
    loop_once();
    check("ext_t1", SEGMENT, 1);
    check("ext_t1_cnt", LOOP_CNT, 0);
    loop_once();
    check("ext_t2", SEGMENT, 0);
    upd(TRANSITION_MODE_SYNC_IDX, 1'b1, 0);
    check("ext_end_hold", SEGMENT, 0);
    loop_once();
    check("ext_end_swap", SEGMENT, 1);
    loop_once();
    check("ext_end_stay", SEGMENT, 1);
    check("ext_end_cnt", LOOP_CNT, 1);

    upd(8'h33, 1'b0, 0);
    check("unk_hold", SEGMENT, 1);
    loop_once();
    check("unk_after", SEGMENT, 1);

    upd(TRANSITION_MODE_SYNC_IDX, 1'b0, 0);
    step(1);
    step(2);
    step(3);
    IDX = '0;
    upd(TRANSITION_MODE_SYS_TIME, 1'b0, 64'h00FF_FFFF_FFFF_FFFF);
    check("upd_wins", SEGMENT, 1);
    step(1);
    check("upd_wins2", SEGMENT, 1);

    upd(TRANSITION_MODE_SYS_TIME, 1'b0, 64'd2000);
    step(2);
    step(3);
    check("coin_pre", SEGMENT, 1);
    SYS_TIME = 56'd2000;
    step(0);
    check("coin_seg", SEGMENT, 0);
    check("coin_cnt", LOOP_CNT, 0);

    upd(TRANSITION_MODE_GPIO, 1'b1, 64'd2);
    GPIO_IN = 4'b0010;
    tick();
    GPIO_IN = 4'b0000;
    tick();
    GPIO_IN = 4'b0010;
    tick();
    check("gpio_pin1", SEGMENT, 0);
    GPIO_IN = 4'b0110;
    tick();
`ifdef MOD_TRANSITION_GPIO_EN
    check("gpio_pin2", SEGMENT, 1);
`else
    check("gpio_off", SEGMENT, 0);
`endif
    GPIO_IN = 4'b0000;
    tick();

    upd(TRANSITION_MODE_IMMEDIATE, 1'b1, 0);
    loop_once();
    check("pre_rst_cnt", LOOP_CNT, 1);
    upd(TRANSITION_MODE_SYNC_IDX, 1'b1, 0);
    #2;
    RST = 1'b1;
    #1;
    check("arst_seg", SEGMENT, 0);
    check("arst_cnt", LOOP_CNT, 0);
    check("arst_stop", STOP, 0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    loop_once();
    check("drop_seg", SEGMENT, 0);
    check("drop_cnt", LOOP_CNT, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
